// File: rtl/vram_arbiter.sv
// Shared 4K x 8 video RAM arbiter between a CPU and a VDG: one access in flight,
// VDG priority with a bounded starvation counter that forces a CPU grant.
module vram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  input  logic              vdg_req,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic [7:0]        vdg_dout,
  output logic              vdg_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_q
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, DATA} state_t;

  state_t            state_q;
  logic              own_cpu_q;
  logic              wr_q;
  logic [CW-1:0]     starve_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_din_q;
  logic              ram_we_q;
  logic              cpu_ack_q, vdg_ack_q;
  logic [7:0]        cpu_dout_q, vdg_dout_q;

  logic gnt_cpu, gnt_vdg;

  always_comb begin
    gnt_cpu = cpu_req && (!vdg_req || (starve_q == SMAX));
    gnt_vdg = vdg_req && !gnt_cpu;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      own_cpu_q  <= 1'b0;
      wr_q       <= 1'b0;
      starve_q   <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vdg_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      vdg_dout_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      vdg_ack_q <= 1'b0;
      ram_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!cpu_req || gnt_cpu)
            starve_q <= '0;
          else if (gnt_vdg && starve_q != SMAX)
            starve_q <= starve_q + 1'b1;
          if (gnt_cpu || gnt_vdg) begin
            state_q    <= ACCESS;
            own_cpu_q  <= gnt_cpu;
            ram_addr_q <= gnt_cpu ? cpu_addr : vdg_addr;
            wr_q       <= gnt_cpu && cpu_we;
            ram_we_q   <= gnt_cpu && cpu_we;
            if (gnt_cpu && cpu_we) ram_din_q <= cpu_din;
          end
        end
        ACCESS: begin
          state_q   <= DATA;
          cpu_ack_q <= own_cpu_q;
          vdg_ack_q <= !own_cpu_q;
        end
        DATA: begin
          state_q <= IDLE;
          if (!wr_q) begin
            if (own_cpu_q) cpu_dout_q <= ram_q;
            else           vdg_dout_q <= ram_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ram_q only becomes valid in DATA, so the ack cycle bypasses it straight
  // through; the dout registers then hold the byte afterwards.
  assign cpu_dout = (cpu_ack_q && !wr_q) ? ram_q : cpu_dout_q;
  assign vdg_dout = vdg_ack_q ? ram_q : vdg_dout_q;
  assign cpu_ack  = cpu_ack_q;
  assign vdg_ack  = vdg_ack_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;

endmodule
